// File: rtl/dmem_lsu.sv
// Byte-addressed B/H/W load/store initiator for a comb-read, sync-write word dmem.
// Latency: loads, word stores and errors respond 1 cycle after accept; sub-word stores 2 cycles.
// Backpressure: one request in flight; req_ready low in RMW/RESP until the response handshakes.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned half/word requests return an error.
module dmem_lsu #(
    parameter int DATA_LENGTH = 32,
    parameter int ADDR_LENGTH = 10
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [1:0]             req_size,
    input  logic                   req_unsigned,
    input  logic [ADDR_LENGTH+1:0] req_addr,
    input  logic [DATA_LENGTH-1:0] req_wdata,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [DATA_LENGTH-1:0] resp_rdata,
    output logic                   resp_err,
    output logic                   mem_we,
    output logic [ADDR_LENGTH-1:0] mem_addr,
    output logic [DATA_LENGTH-1:0] mem_wdata,
    input  logic [DATA_LENGTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RMW  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state;
    logic [ADDR_LENGTH-1:0] addr_q;
    logic [DATA_LENGTH-1:0] merged_q;

    logic                   accept;
    logic [ADDR_LENGTH-1:0] word;
    logic [1:0]             off;
    logic                   size_illegal;
    logic                   misaligned;
    logic                   req_err;
    logic [7:0]             byte_sel;
    logic [15:0]            half_sel;
    logic [DATA_LENGTH-1:0] load_data;
    logic [DATA_LENGTH-1:0] merged;

    assign req_ready    = (state == IDLE);
    assign accept       = req_valid & req_ready;
    assign word         = req_addr[ADDR_LENGTH+1:2];
    assign off          = req_addr[1:0];
    assign size_illegal = (req_size == 2'b11);
    assign misaligned   = ((req_size == 2'b01) & off[0]) |
                          ((req_size == 2'b10) & (off != 2'b00));

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_err = size_illegal | misaligned;
`else
    // Misaligned halves/words are silently aligned: lane selection below already
    // ignores off[0] for halves and the whole offset for words.
    assign req_err = size_illegal | (misaligned & 1'b0);
`endif

    // Lane extraction and sign/zero extension for loads.
    always_comb begin
        byte_sel  = mem_rdata[{off, 3'b000} +: 8];
        half_sel  = mem_rdata[{off[1], 4'b0000} +: 16];
        load_data = mem_rdata;
        case (req_size)
            2'b00:   load_data = {{(DATA_LENGTH-8){~req_unsigned & byte_sel[7]}}, byte_sel};
            2'b01:   load_data = {{(DATA_LENGTH-16){~req_unsigned & half_sel[15]}}, half_sel};
            default: load_data = mem_rdata;
        endcase
    end

    // Insert the store lane into the current word for the read-modify-write.
    always_comb begin
        merged = mem_rdata;
        if (req_size == 2'b00) begin
            merged[{off, 3'b000} +: 8] = req_wdata[7:0];
        end else begin
            merged[{off[1], 4'b0000} +: 16] = req_wdata[15:0];
        end
    end

    // dmem drive: IDLE presents the incoming request, RMW writes back the merged word.
    always_comb begin
        mem_we    = reset_n & (((state == IDLE) & accept & req_we & (req_size == 2'b10) & ~req_err)
                               | (state == RMW));
        mem_addr  = (state == IDLE) ? word : addr_q;
        mem_wdata = (state == IDLE) ? req_wdata : merged_q;
    end

    // Request/response FSM with registered response outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            addr_q     <= '0;
            merged_q   <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q <= word;
                        if (req_err) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= '0;
                            resp_err   <= 1'b1;
                        end else if (!req_we) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= load_data;
                            resp_err   <= 1'b0;
                        end else if (req_size == 2'b10) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= '0;
                            resp_err   <= 1'b0;
                        end else begin
                            state    <= RMW;
                            merged_q <= merged;
                        end
                    end
                end
                RMW: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
module tb_dmem_lsu;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_lsu #(.DATA_LENGTH(32), .ADDR_LENGTH(10)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // dmem model: combinational read, synchronous write, preloaded on the first edge.
    logic [31:0] mem [0:1023];
    logic        loaded = 1'b0;
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
            mem[2]  <= 32'h5566_F788;
            mem[3]  <= 32'h1122_3344;
            mem[4]  <= 32'h0102_0304;
            mem[5]  <= 32'h8081_F2F3;
            loaded  <= 1'b1;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] e_rdata;
        logic        e_err;
        int          e_lat;
        int          e_we_acc;
        int          e_we_tot;
    } vec_t;

    vec_t vecs[16];

    // One full transaction with resp_ready held high; called #1 after a posedge.
    task automatic run_req(input vec_t v, output int lat, output logic [31:0] rdata,
                           output logic err, output int we_acc, output int we_tot);
        req_valid    = 1'b1;
        req_we       = v.we;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        resp_ready   = 1'b1;
        @(negedge clk);
        we_acc = int'(mem_we);
        we_tot = int'(mem_we);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(negedge clk);
            we_tot += int'(mem_we);
            @(posedge clk); #1;
            lat++;
        end
        rdata = resp_rdata;
        err   = resp_err;
        @(negedge clk);
        we_tot += int'(mem_we);
        @(posedge clk); #1;
    endtask

    initial begin
        int          lat, we_acc, we_tot;
        logic [31:0] rdata;
        logic        err;

        //           we    size   uns   addr     wdata          e_rdata        e_err lat acc tot
        vecs[0]  = '{1'b0, 2'b00, 1'b0, 12'h015, 32'h0,         32'hFFFF_FFF2, 1'b0, 1, 0, 0};
        vecs[1]  = '{1'b0, 2'b00, 1'b1, 12'h015, 32'h0,         32'h0000_00F2, 1'b0, 1, 0, 0};
        vecs[2]  = '{1'b0, 2'b01, 1'b0, 12'h016, 32'h0,         32'hFFFF_8081, 1'b0, 1, 0, 0};
        vecs[3]  = '{1'b0, 2'b01, 1'b1, 12'h014, 32'h0,         32'h0000_F2F3, 1'b0, 1, 0, 0};
        vecs[4]  = '{1'b0, 2'b10, 1'b0, 12'h014, 32'h0,         32'h8081_F2F3, 1'b0, 1, 0, 0};
        vecs[5]  = '{1'b0, 2'b00, 1'b0, 12'h017, 32'h0,         32'hFFFF_FF80, 1'b0, 1, 0, 0};
        vecs[6]  = '{1'b1, 2'b00, 1'b0, 12'h00E, 32'h0000_00AA, 32'h0,         1'b0, 2, 0, 1};
        vecs[7]  = '{1'b0, 2'b10, 1'b0, 12'h00C, 32'h0,         32'h11AA_3344, 1'b0, 1, 0, 0};
        vecs[8]  = '{1'b1, 2'b01, 1'b0, 12'h00C, 32'hCAFE_1234, 32'h0,         1'b0, 2, 0, 1};
        vecs[9]  = '{1'b0, 2'b10, 1'b0, 12'h00C, 32'h0,         32'h11AA_1234, 1'b0, 1, 0, 0};
        vecs[10] = '{1'b0, 2'b01, 1'b0, 12'h009, 32'h0,
                     EN ? 32'h0 : 32'hFFFF_F788, EN, 1, 0, 0};
        vecs[11] = '{1'b0, 2'b11, 1'b0, 12'h008, 32'h0,         32'h0,         1'b1, 1, 0, 0};
        vecs[12] = '{1'b1, 2'b11, 1'b0, 12'h008, 32'hFFFF_FFFF, 32'h0,         1'b1, 1, 0, 0};
        vecs[13] = '{1'b0, 2'b10, 1'b0, 12'h008, 32'h0,         32'h5566_F788, 1'b0, 1, 0, 0};
        vecs[14] = '{1'b0, 2'b10, 1'b0, 12'h00B, 32'h0,
                     EN ? 32'h0 : 32'h5566_F788, EN, 1, 0, 0};
        vecs[15] = '{1'b0, 2'b00, 1'b1, 12'h00B, 32'h0,         32'h0000_0055, 1'b0, 1, 0, 0};

        // Reset held with a pending word store: no write may escape.
        reset_n      = 1'b0;
        req_valid    = 1'b1;
        req_we       = 1'b1;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_addr     = 12'h020;
        req_wdata    = 32'h1234_5678;
        resp_ready   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("reset_mem_we", {31'b0, mem_we}, 32'h0);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset_n   = 1'b1;
        chk("reset_resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("reset_req_ready",  {31'b0, req_ready},  32'h1);
        chk("reset_resp_rdata", resp_rdata, 32'h0);
        chk("reset_resp_err",   {31'b0, resp_err},   32'h0);
        chk("reset_mem8",       mem[8], 32'h0);

        // Table-driven transactions.
        for (int i = 0; i < 16; i++) begin
            run_req(vecs[i], lat, rdata, err, we_acc, we_tot);
            chk($sformatf("v%0d_rdata", i), rdata, vecs[i].e_rdata);
            chk($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, vecs[i].e_err});
            chk($sformatf("v%0d_lat", i), lat, vecs[i].e_lat);
            chk($sformatf("v%0d_we_accept", i), we_acc, vecs[i].e_we_acc);
            chk($sformatf("v%0d_we_total", i), we_tot, vecs[i].e_we_tot);
            chk($sformatf("v%0d_req_ready", i), {31'b0, req_ready}, 32'h1);
        end
        chk("mem3_after_stores", mem[3], 32'h11AA_1234);
        chk("mem2_untouched", mem[2], 32'h5566_F788);

        // Word store with response backpressure.
        resp_ready   = 1'b0;
        req_valid    = 1'b1;
        req_we       = 1'b1;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_addr     = 12'h020;
        req_wdata    = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("ws_mem_we_accept", {31'b0, mem_we}, 32'h1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("ws_mem8", mem[8], 32'hDEAD_BEEF);
        chk("ws_resp_valid", {31'b0, resp_valid}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ws_hold_mem_we", {31'b0, mem_we}, 32'h0);
            @(posedge clk); #1;
            chk("ws_hold_resp_valid", {31'b0, resp_valid}, 32'h1);
            chk("ws_hold_req_ready",  {31'b0, req_ready},  32'h0);
            chk("ws_hold_rdata",      resp_rdata, 32'h0);
            chk("ws_hold_err",        {31'b0, resp_err}, 32'h0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("ws_done_resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("ws_done_req_ready",  {31'b0, req_ready},  32'h1);

        // Sub-word store aborted by reset during RMW.
        req_valid    = 1'b1;
        req_we       = 1'b1;
        req_size     = 2'b00;
        req_addr     = 12'h011;
        req_wdata    = 32'h0000_0099;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rmw_abort_req_ready", {31'b0, req_ready}, 32'h0);
        reset_n = 1'b0;
        @(negedge clk);
        chk("rmw_abort_mem_we", {31'b0, mem_we}, 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk("rmw_abort_mem4", mem[4], 32'h0102_0304);
        for (int i = 0; i < 3; i++) begin
            chk("rmw_abort_no_resp", {31'b0, resp_valid}, 32'h0);
            @(posedge clk); #1;
        end
        chk("rmw_abort_req_ready_after", {31'b0, req_ready}, 32'h1);
        chk("rmw_abort_mem4_final", mem[4], 32'h0102_0304);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
